pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the next-generation pipelined CPU.
- Replaces the fixed IDEX/EXMEM/MEMWB comparison logic with an internal scoreboard covering DEPTH post-decode stages.
- Adds an operand-forwarding select, load-use detection, a pipeline-hold input, and a control-transfer FSM with a configurable flush shadow.
- Sits beside decode and drives the IF/ID and ID/EX stall and flush controls.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked post-decode stages. Stage 0 = EX, stage DEPTH-1 = WB.
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any in-flight producer.
- LOAD_STAGE, 2, first stage index whose output carries load data.
- SHADOW, 2, flush cycles after a redirect (range 1..15).
- ZERO_HARD, 1, 1 = register 0 never causes a hazard.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- id_valid  in  1  decode stage holds an instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_rs1_en, id_rs2_en  in  1  source register is actually read.
- id_rd  in  REG_AW  destination register.
- id_rd_we  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a memory load.
- id_is_ctrl  in  1  instruction is a branch, call or return.
- redirect  in  1  one-cycle PC-update pulse from the resolving stage.
- hold  in  1  global pipeline freeze (memory busy).
- issue  out  1  decode instruction advances into stage 0 this cycle.
- stall_id  out  1  hold the PC and IF/ID register.
- flush_ifid  out  1  discard the IF/ID contents.
- flush_idex  out  1  insert a bubble into ID/EX.
- fwd_sel1, fwd_sel2  out  $clog2(DEPTH+1)  0 = register file; k+1 = result from stage k.
- ctrl_pending  out  1  FSM is not in IDLE.

Behaviour:
- Scoreboard: per stage k, store {v, rd, we, ld}.
  - On each clock edge with hold=0: stage0 <= issue ? {1, id_rd, id_rd_we, id_is_load} : 0; stage k <= stage k-1. The entry leaving stage DEPTH-1 is dropped.
  - With hold=1 the scoreboard is frozen.
- Match for source s at stage k: v & we & rd==rs & rs_en & !(ZERO_HARD & rs==0). The youngest match (lowest k) decides.
- With FWD_EN=1:
  - youngest match has ld=1 and k<LOAD_STAGE -> data_stall;
  - otherwise fwd_sel = k+1;
  - no match -> fwd_sel = 0.
- With FWD_EN=0: any match -> data_stall, and fwd_sel is always 0.
- FSM states:
  - IDLE: an issued ctrl instruction moves the FSM to WAIT.
  - WAIT: redirect moves to SHADOW and loads cnt=SHADOW.
  - SHADOW: cnt decrements each non-hold cycle; cnt reaching 1 moves the FSM to IDLE.
- Redirect in any state, including IDLE and SHADOW, moves to SHADOW and reloads cnt=SHADOW.
- Redirect is sampled even when hold=1. The FSM updates under hold only on redirect.
- issue = id_valid & !data_stall & !hold & !redirect & state==IDLE.
- stall_id = hold | data_stall | state==WAIT.
- flush_ifid = redirect | state==WAIT | state==SHADOW.
- flush_idex = !hold & !issue. A bubble is inserted into ID/EX whenever nothing issues.
- A redirect kills the decode instruction in the same cycle: it is not issued and no scoreboard entry is created.
- All outputs are combinational from state and inputs, with zero-cycle latency. Scoreboard and FSM effects appear one cycle later.
- Reset: all v=0, FSM=IDLE, cnt=0.
  - With idle inputs, outputs read issue=0, stall_id=0, flush_ifid=0, flush_idex=1, fwd_sel=0, ctrl_pending=0.
- Asserting reset mid-operation clears all in-flight entries immediately.

Test Plan:
1. FWD_EN=1: issue ADD r3, then next cycle id_rs1=3 (ALU producer) -> issue=1, fwd_sel1=1; next-next cycle fwd_sel1=2.
2. LOAD r4 followed immediately by a reader of r4 (LOAD_STAGE=2) -> stall_id=1 and flush_idex=1 for 2 cycles, then issue=1 with fwd_sel1=3.
3. FWD_EN=0, DEPTH=3: producer r5 then reader of r5 -> stall_id=1 for 3 cycles, fwd_sel1=0 throughout, then issue.
4. Branch issues, redirect arrives 2 cycles later (SHADOW=2) -> stall_id=1 and flush_ifid=1 in both WAIT cycles; flush_ifid=1 for 2 further cycles; ctrl_pending drops to 0 on cycle 5.
5. id_rs1=0 with r0 in flight and ZERO_HARD=1 -> no stall, fwd_sel1=0.
6. hold=1 for 3 cycles with r6 in stage 0 -> issue=0, flush_idex=0, scoreboard unchanged; after release fwd_sel1 advances 1→2. Reset asserted mid-stream -> all outputs return to reset values on the same edge.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Decode-side bundle of the hazard controller: instruction fields in, issue,
// stall, flush and forwarding controls out.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_en;
  logic              id_rs2_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              id_is_ctrl;
  logic              redirect;
  logic              hold;

  logic              issue;
  logic              stall_id;
  logic              flush_ifid;
  logic              flush_idex;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic              ctrl_pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_we,
           id_is_load, id_is_ctrl, redirect, hold,
    input  issue, stall_id, flush_ifid, flush_idex, fwd_sel1, fwd_sel2,
           ctrl_pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_we,
           id_is_load, id_is_ctrl, redirect, hold,
    output issue, stall_id, flush_ifid, flush_idex, fwd_sel1, fwd_sel2,
           ctrl_pending
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: DEPTH-stage destination scoreboard, load-use
// and no-forward stalls, and a redirect flush FSM with a SHADOW-cycle tail.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_STAGE = 2,
  parameter int SHADOW     = 2,
  parameter int ZERO_HARD  = 1
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave hz
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHADOW} state_t;

  state_t            state;
  logic [3:0]        cnt;

  logic [DEPTH-1:0]  sb_v;
  logic [DEPTH-1:0]  sb_we;
  logic [DEPTH-1:0]  sb_ld;
  logic [REG_AW-1:0] sb_rd [DEPTH];

  logic              hit1, hit2;
  logic              early1, early2;
  logic [SEL_W-1:0]  sel1, sel2;
  logic              data_stall;
  logic              issue;

  // Youngest-match search: scan oldest to youngest so the lowest stage wins.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    early1 = 1'b0;
    early2 = 1'b0;
    sel1   = '0;
    sel2   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_v[k] && sb_we[k] && hz.id_rs1_en && (sb_rd[k] == hz.id_rs1) &&
          !((ZERO_HARD != 0) && (hz.id_rs1 == '0))) begin
        hit1   = 1'b1;
        early1 = sb_ld[k] && (k < LOAD_STAGE);
        sel1   = SEL_W'(k + 1);
      end
      if (sb_v[k] && sb_we[k] && hz.id_rs2_en && (sb_rd[k] == hz.id_rs2) &&
          !((ZERO_HARD != 0) && (hz.id_rs2 == '0))) begin
        hit2   = 1'b1;
        early2 = sb_ld[k] && (k < LOAD_STAGE);
        sel2   = SEL_W'(k + 1);
      end
    end
  end

  assign data_stall = (FWD_EN != 0) ? (early1 | early2) : (hit1 | hit2);

  assign issue = hz.id_valid & ~data_stall & ~hz.hold & ~hz.redirect &
                 (state == ST_IDLE);

  assign hz.issue        = issue;
  assign hz.stall_id     = hz.hold | data_stall | (state == ST_WAIT);
  assign hz.flush_ifid   = hz.redirect | (state == ST_WAIT) | (state == ST_SHADOW);
  assign hz.flush_idex   = ~hz.hold & ~issue;
  assign hz.fwd_sel1     = ((FWD_EN != 0) && hit1 && !early1) ? sel1 : '0;
  assign hz.fwd_sel2     = ((FWD_EN != 0) && hit2 && !early2) ? sel2 : '0;
  assign hz.ctrl_pending = (state != ST_IDLE);

  // ID -> stage 0 boundary; older entries shift toward WB, frozen under hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v <= '0;
    end else if (!hz.hold) begin
      sb_v[0] <= issue;
      for (int k = 1; k < DEPTH; k++) sb_v[k] <= sb_v[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!hz.hold) begin
      sb_rd[0] <= hz.id_rd;
      sb_we[0] <= hz.id_rd_we;
      sb_ld[0] <= hz.id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        sb_rd[k] <= sb_rd[k-1];
        sb_we[k] <= sb_we[k-1];
        sb_ld[k] <= sb_ld[k-1];
      end
    end
  end

  // Redirect wins in every state and even under hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (hz.redirect) begin
      state <= ST_SHADOW;
      cnt   <= 4'(SHADOW);
    end else if (!hz.hold) begin
      case (state)
        ST_IDLE: if (issue && hz.id_is_ctrl) state <= ST_WAIT;
        ST_WAIT: state <= ST_WAIT;
        ST_SHADOW: begin
          if (cnt <= 4'd1) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance A forwards, instance B
// stalls on any in-flight producer.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_if #(.REG_AW(5), .DEPTH(3)) ifa ();
  pipe_hazard_if #(.REG_AW(5), .DEPTH(3)) ifb ();

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .LOAD_STAGE(2),
                     .SHADOW(2), .ZERO_HARD(1))
    dut_a (.clk(clk), .rst(rst), .hz(ifa));

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .LOAD_STAGE(2),
                     .SHADOW(2), .ZERO_HARD(1))
    dut_b (.clk(clk), .rst(rst), .hz(ifb));

  int n_vec = 0;
  int n_err = 0;

  // {issue, stall_id, flush_ifid, flush_idex, ctrl_pending}
  function automatic logic [4:0] ctl_a();
    return {ifa.issue, ifa.stall_id, ifa.flush_ifid, ifa.flush_idex, ifa.ctrl_pending};
  endfunction

  function automatic logic [4:0] ctl_b();
    return {ifb.issue, ifb.stall_id, ifb.flush_ifid, ifb.flush_idex, ifb.ctrl_pending};
  endfunction

  task automatic set_a(input int v, input int rs1, input int e1, input int rs2,
                       input int e2, input int rd, input int we, input int ld,
                       input int ctrl);
    ifa.id_valid   = (v != 0);
    ifa.id_rs1     = 5'(rs1);
    ifa.id_rs1_en  = (e1 != 0);
    ifa.id_rs2     = 5'(rs2);
    ifa.id_rs2_en  = (e2 != 0);
    ifa.id_rd      = 5'(rd);
    ifa.id_rd_we   = (we != 0);
    ifa.id_is_load = (ld != 0);
    ifa.id_is_ctrl = (ctrl != 0);
  endtask

  task automatic set_b(input int v, input int rs1, input int e1, input int rd,
                       input int we);
    ifb.id_valid   = (v != 0);
    ifb.id_rs1     = 5'(rs1);
    ifb.id_rs1_en  = (e1 != 0);
    ifb.id_rs2     = 5'd0;
    ifb.id_rs2_en  = 1'b0;
    ifb.id_rd      = 5'(rd);
    ifb.id_rd_we   = (we != 0);
    ifb.id_is_load = 1'b0;
    ifb.id_is_ctrl = 1'b0;
  endtask

  task automatic idle_all();
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    ifa.redirect = 1'b0;
    ifa.hold     = 1'b0;
    ifb.redirect = 1'b0;
    ifb.hold     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drain();
    idle_all();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    repeat (2) @(posedge clk);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b00010) begin
      n_err++; $display("FAIL rst_ctl_a got %b want 00010", ctl_a());
    end
    n_vec++;
    if ({ifa.fwd_sel1, ifa.fwd_sel2} !== 4'b0000) begin
      n_err++; $display("FAIL rst_sel_a got %b want 0000", {ifa.fwd_sel1, ifa.fwd_sel2});
    end
    n_vec++;
    if (ctl_b() !== 5'b00010) begin
      n_err++; $display("FAIL rst_ctl_b got %b want 00010", ctl_b());
    end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_fwd();
    set_a(1, 0, 0, 0, 0, 3, 1, 0, 0);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000) begin
      n_err++; $display("FAIL alu_c0_ctl got %b want 10000", ctl_a());
    end
    tick();
    set_a(1, 3, 1, 0, 0, 7, 1, 0, 0);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd1) begin
      n_err++; $display("FAIL alu_c1 ctl=%b sel1=%0d want 10000 sel1=1", ctl_a(), ifa.fwd_sel1);
    end
    tick();
    set_a(1, 3, 1, 7, 1, 0, 0, 0, 0);
    samp();
    n_vec++;
    if (ifa.fwd_sel1 !== 2'd2 || ifa.fwd_sel2 !== 2'd1 || ctl_a() !== 5'b10000) begin
      n_err++; $display("FAIL alu_c2 sel1=%0d sel2=%0d ctl=%b want 2 1 10000",
                        ifa.fwd_sel1, ifa.fwd_sel2, ctl_a());
    end
    tick();
    set_a(1, 3, 1, 0, 0, 0, 0, 0, 0);
    samp();
    n_vec++;
    if (ifa.fwd_sel1 !== 2'd3) begin
      n_err++; $display("FAIL alu_c3_sel1 got %0d want 3", ifa.fwd_sel1);
    end
    tick();
    samp();
    n_vec++;
    if (ifa.fwd_sel1 !== 2'd0) begin
      n_err++; $display("FAIL alu_c4_sel1 got %0d want 0", ifa.fwd_sel1);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_a(1, 0, 0, 0, 0, 4, 1, 1, 0);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000) begin
      n_err++; $display("FAIL ld_c0_ctl got %b want 10000", ctl_a());
    end
    tick();
    set_a(1, 4, 1, 0, 0, 8, 1, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      samp();
      n_vec++;
      if (ctl_a() !== 5'b01010) begin
        n_err++; $display("FAIL ld_stall_c%0d got %b want 01010", c, ctl_a());
      end
      tick();
    end
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd3) begin
      n_err++; $display("FAIL ld_c3 ctl=%b sel1=%0d want 10000 sel1=3", ctl_a(), ifa.fwd_sel1);
    end
    drain();
  endtask

  task automatic test_no_fwd();
    set_b(1, 0, 0, 5, 1);
    samp();
    n_vec++;
    if (ctl_b() !== 5'b10000) begin
      n_err++; $display("FAIL nf_c0_ctl got %b want 10000", ctl_b());
    end
    tick();
    set_b(1, 5, 1, 2, 1);
    for (int c = 1; c <= 3; c++) begin
      samp();
      n_vec++;
      if (ctl_b() !== 5'b01010 || ifb.fwd_sel1 !== 2'd0) begin
        n_err++; $display("FAIL nf_stall_c%0d ctl=%b sel1=%0d want 01010 sel1=0",
                          c, ctl_b(), ifb.fwd_sel1);
      end
      tick();
    end
    samp();
    n_vec++;
    if (ctl_b() !== 5'b10000 || ifb.fwd_sel1 !== 2'd0) begin
      n_err++; $display("FAIL nf_c4 ctl=%b sel1=%0d want 10000 sel1=0", ctl_b(), ifb.fwd_sel1);
    end
    drain();
  endtask

  task automatic test_branch();
    logic [4:0] exp_ctl [6];
    exp_ctl = '{5'b10000, 5'b01111, 5'b01111, 5'b00111, 5'b00111, 5'b10000};
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) set_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
      ifa.redirect = (c == 2);
      samp();
      n_vec++;
      if (ctl_a() !== exp_ctl[c]) begin
        n_err++; $display("FAIL br_c%0d got %b want %b", c, ctl_a(), exp_ctl[c]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_zero_reg();
    set_a(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    set_a(1, 0, 1, 0, 1, 0, 0, 0, 0);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd0 || ifa.fwd_sel2 !== 2'd0) begin
      n_err++; $display("FAIL zero_reg ctl=%b sel1=%0d sel2=%0d want 10000 0 0",
                        ctl_a(), ifa.fwd_sel1, ifa.fwd_sel2);
    end
    drain();
  endtask

  task automatic test_hold();
    set_a(1, 0, 0, 0, 0, 6, 1, 0, 0);
    tick();
    set_a(1, 6, 1, 0, 0, 0, 0, 0, 0);
    ifa.hold = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      samp();
      n_vec++;
      if (ctl_a() !== 5'b01000 || ifa.fwd_sel1 !== 2'd1) begin
        n_err++; $display("FAIL hold_c%0d ctl=%b sel1=%0d want 01000 sel1=1",
                          c, ctl_a(), ifa.fwd_sel1);
      end
      tick();
    end
    ifa.hold = 1'b0;
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd1) begin
      n_err++; $display("FAIL hold_rel0 ctl=%b sel1=%0d want 10000 sel1=1", ctl_a(), ifa.fwd_sel1);
    end
    tick();
    samp();
    n_vec++;
    if (ifa.fwd_sel1 !== 2'd2) begin
      n_err++; $display("FAIL hold_rel1_sel1 got %0d want 2", ifa.fwd_sel1);
    end
    drain();
  endtask

  task automatic test_redirect_kill();
    set_a(1, 0, 0, 0, 0, 10, 1, 0, 0);
    ifa.redirect = 1'b1;
    samp();
    n_vec++;
    if (ctl_a() !== 5'b00110) begin
      n_err++; $display("FAIL kill_c0 got %b want 00110", ctl_a());
    end
    tick();
    ifa.redirect = 1'b0;
    set_a(1, 10, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      samp();
      n_vec++;
      if (ctl_a() !== 5'b00111 || ifa.fwd_sel1 !== 2'd0) begin
        n_err++; $display("FAIL kill_c%0d ctl=%b sel1=%0d want 00111 sel1=0",
                          c, ctl_a(), ifa.fwd_sel1);
      end
      tick();
    end
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd0) begin
      n_err++; $display("FAIL kill_c3 ctl=%b sel1=%0d want 10000 sel1=0", ctl_a(), ifa.fwd_sel1);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    set_a(1, 0, 0, 0, 0, 9, 1, 0, 1);
    tick();
    set_a(1, 9, 1, 0, 0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (ctl_a() !== 5'b01111 || ifa.fwd_sel1 !== 2'd1) begin
      n_err++; $display("FAIL mrst_pre ctl=%b sel1=%0d want 01111 sel1=1", ctl_a(), ifa.fwd_sel1);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (ifa.fwd_sel1 !== 2'd0) begin
      n_err++; $display("FAIL mrst_sel1 got %0d want 0", ifa.fwd_sel1);
    end
    idle_all();
    #1;
    n_vec++;
    if (ctl_a() !== 5'b00010) begin
      n_err++; $display("FAIL mrst_ctl got %b want 00010", ctl_a());
    end
    samp();
    rst = 1'b1;
    tick();
    set_a(1, 9, 1, 0, 0, 0, 0, 0, 0);
    samp();
    n_vec++;
    if (ctl_a() !== 5'b10000 || ifa.fwd_sel1 !== 2'd0) begin
      n_err++; $display("FAIL mrst_post ctl=%b sel1=%0d want 10000 sel1=0", ctl_a(), ifa.fwd_sel1);
    end
    drain();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_no_fwd();
    test_branch();
    test_zero_reg();
    test_hold();
    test_redirect_kill();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
